// File: rtl/csm_signed_pipe.sv
// Signed 4x4 Baugh-Wooley carry-save multiplier, 3 register stages: a,b at edge N -> y after edge N+2.
// No backpressure: one operand pair accepted every cycle, result stream never stalls.
module csm_signed_pipe (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] a,
   input  logic [3:0] b,
   output logic [7:0] y
);

   logic [7:0] w_pp0;
   logic [7:0] w_pp1;
   logic [7:0] w_pp2;
   logic [7:0] w_pp3;
   logic [7:0] w_s1_sum;
   logic [7:0] w_s1_cry;
   logic [7:0] w_s2_sum;
   logic [7:0] w_s2_cry;
   logic [7:0] w_merge;

   logic [7:0] r_s1_sum;
   logic [7:0] r_s1_cry;
   logic [7:0] r_s1_pp3;
   logic [7:0] r_s2_sum;
   logic [7:0] r_s2_cry;
   logic [7:0] r_y;

   // Row 0 also carries the Baugh-Wooley correction constant (bits 4 and 7),
   // so a cleared pipeline holds no hidden bias and merges to zero.
   always_comb begin
      w_pp0      = 8'h90;
      w_pp0[2:0] = a[2:0] & {3{b[0]}};
      w_pp0[3]   = ~(a[3] & b[0]);

      w_pp1      = '0;
      w_pp1[3:1] = a[2:0] & {3{b[1]}};
      w_pp1[4]   = ~(a[3] & b[1]);

      w_pp2      = '0;
      w_pp2[4:2] = a[2:0] & {3{b[2]}};
      w_pp2[5]   = ~(a[3] & b[2]);

      w_pp3      = '0;
      w_pp3[5:3] = ~(a[2:0] & {3{b[3]}});
      w_pp3[6]   = a[3] & b[3];
   end

   always_comb begin
      w_s1_sum      = w_pp0 ^ w_pp1 ^ w_pp2;
      w_s1_cry[0]   = 1'b0;
      w_s1_cry[7:1] = (w_pp0[6:0] & w_pp1[6:0]) | (w_pp0[6:0] & w_pp2[6:0]) |
                      (w_pp1[6:0] & w_pp2[6:0]);
   end

   always_comb begin
      w_s2_sum      = r_s1_sum ^ r_s1_cry ^ r_s1_pp3;
      w_s2_cry[0]   = 1'b0;
      w_s2_cry[7:1] = (r_s1_sum[6:0] & r_s1_cry[6:0]) | (r_s1_sum[6:0] & r_s1_pp3[6:0]) |
                      (r_s1_cry[6:0] & r_s1_pp3[6:0]);
   end

   // Vector-merge ripple adder; carry out of bit 7 is dropped (result is mod 256).
   always_comb begin
      logic [7:0] c;
      c    = '0;
      for (int i = 0; i < 7; i++) begin
         c[i+1] = (r_s2_sum[i] & r_s2_cry[i]) | (r_s2_sum[i] & c[i]) | (r_s2_cry[i] & c[i]);
      end
      w_merge = r_s2_sum ^ r_s2_cry ^ c;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_s1_sum <= '0;
         r_s1_cry <= '0;
         r_s1_pp3 <= '0;
         r_s2_sum <= '0;
         r_s2_cry <= '0;
         r_y      <= '0;
      end else begin
         r_s1_sum <= w_s1_sum;
         r_s1_cry <= w_s1_cry;
         r_s1_pp3 <= w_pp3;
         r_s2_sum <= w_s2_sum;
         r_s2_cry <= w_s2_cry;
         r_y      <= w_merge;
      end
   end

   assign y = r_y;

endmodule

// File: tb/tb_csm_signed_pipe.sv
// Scoreboard bench for csm_signed_pipe: stimulus pushes expected products, a monitor pops on emergence.
module tb_csm_signed_pipe;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] a;
   logic [3:0] b;
   logic [7:0] y;

   logic [7:0] exp_q[$];
   int         issue;        // 0: nothing expected, 1: y must be zero, 2: product from exp_q
   int         n_cmp = 0;
   int         n_err = 0;

   csm_signed_pipe dut (
      .clk(clk),
      .rst(rst),
      .a  (a),
      .b  (b),
      .y  (y)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] model(input logic [3:0] x, input logic [3:0] z);
      int p;
      p = int'($signed(x)) * int'($signed(z));
      return p[7:0];
   endfunction

   task automatic drive(input logic [3:0] ia, input logic [3:0] ib, input logic [7:0] ey);
      @(negedge clk);
      rst   = 1'b0;
      a     = ia;
      b     = ib;
      issue = 2;
      exp_q.push_back(ey);
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         rst   = 1'b0;
         issue = 0;
      end
   endtask

   task automatic reset_cyc(input int n);
      repeat (n) begin
         @(negedge clk);
         rst   = 1'b1;
         a     = 4'h7;
         b     = 4'h7;
         issue = 1;
      end
   endtask

   // Monitor: tracks what was captured at each edge; checks y 1 time unit after the edge where it emerges.
   initial begin : monitor
      int         d0;
      int         d1;
      int         d2;
      logic       r;
      logic [7:0] e;
      d0 = 0;
      d1 = 0;
      d2 = 0;
      forever begin
         @(posedge clk);
         r  = rst;
         d2 = d1;
         d1 = d0;
         d0 = issue;
         if (r === 1'b1) begin
            if (d2 == 2 && exp_q.size() > 0) void'(exp_q.pop_front());
            if (d1 == 2 && exp_q.size() > 0) void'(exp_q.pop_front());
            d0 = 1;
            d1 = 1;
            d2 = 1;
         end
         #1;
         if (d2 == 1) begin
            n_cmp++;
            if (y !== 8'h00) begin
               n_err++;
               $display("FAIL zero_state: y=%h expected 00 at %0t", y, $time);
            end
         end else if (d2 == 2) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
               n_err++;
               $display("FAIL scoreboard_underflow: y=%h with no expected entry at %0t", y, $time);
            end else begin
               e = exp_q.pop_front();
               if (y !== e) begin
                  n_err++;
                  $display("FAIL product: y=%h expected %h at %0t", y, e, $time);
               end
            end
         end
      end
   end

   // {a, b, y} directed vectors: back-to-back stream, then corner operands
   logic [15:0] dir_tab[10] = '{
      16'h87C8, 16'h4410, 16'h5CEC, 16'h3EFA, 16'h7731,
      16'h8840, 16'hFF01, 16'h81F8, 16'h0B00, 16'h78C8
   };

   initial begin : stim
      logic [15:0] v;
      rst   = 1'b1;
      a     = 4'h0;
      b     = 4'h0;
      issue = 1;
      @(negedge clk);

      // latency: 4 * -2 = -8 after two reset edges
      drive(4'h4, 4'hE, 8'hF8);
      idle(3);

      for (int i = 0; i < 10; i++) begin
         v = dir_tab[i];
         drive(v[15:12], v[11:8], v[7:0]);
      end
      idle(3);

      // hold (3,-2) for 10 cycles
      repeat (10) drive(4'h3, 4'hE, 8'hFA);
      idle(3);

      // reset while two products are in flight; they must never appear
      drive(4'h3, 4'h3, 8'h09);
      drive(4'hE, 4'h5, 8'hF6);
      reset_cyc(2);
      drive(4'h2, 4'h3, 8'h06);
      idle(3);

      for (int i = 0; i < 16; i++) begin
         for (int j = 0; j < 16; j++) begin
            logic [3:0] ta;
            logic [3:0] tb;
            ta = i[3:0];
            tb = j[3:0];
            drive(ta, tb, model(ta, tb));
         end
      end
      idle(1);

      for (int k = 0; k < 8 && exp_q.size() != 0; k++) @(negedge clk);
      if (exp_q.size() != 0) begin
         n_cmp++;
         n_err++;
         $display("FAIL drain_timeout: %0d expected results never emerged, required 0", exp_q.size());
      end
      idle(2);

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
      $finish;
   end

endmodule
